// File: rtl/wb_ram_responder_pkg.sv
// Shared definitions for the word-RAM bus responder: FSM encodings,
// byte-lane select constants shared with the CPU, and a wait-load helper.
package wb_ram_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Byte-lane selects; sel[0] covers data bits 7:0.
    localparam logic [3:0] SEL_WORD    = 4'b1111;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_BYTE0   = 4'b0001;
    localparam logic [3:0] SEL_BYTE1   = 4'b0010;
    localparam logic [3:0] SEL_BYTE2   = 4'b0100;
    localparam logic [3:0] SEL_BYTE3   = 4'b1000;

    localparam int WAIT_MAX = 15;

    // Value loaded into the wait counter on accept; the WAIT state is
    // skipped entirely when no wait states are configured.
    function automatic logic [3:0] wait_load(input int ws);
        if (ws <= 0) begin
            return 4'd0;
        end
        return 4'(ws - 1);
    endfunction

endpackage

// File: rtl/wb_ram_responder_if.sv
// Memory bus between the CPU (master) and the RAM responder (slave).
//
// Handshake: the master raises stb_i with we_i/adr_i/dat_i/sel_i stable
// and keeps stb_i high until it samples ack_o. ack_o is a one-cycle pulse;
// for reads dat_o is valid in the ack cycle and stays valid until the next
// read completes. A transaction is counted once per stb_i high period.
interface wb_ram_responder_if;
    logic        stb_i;
    logic        we_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic        ack_o;
    logic [31:0] dat_o;

    modport master (
        output stb_i, we_i, adr_i, dat_i, sel_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  stb_i, we_i, adr_i, dat_i, sel_i,
        output ack_o, dat_o
    );
endinterface

// File: rtl/wb_ram_responder_byte_array.sv
// Four byte-wide RAM arrays with per-lane write enables and a shared
// synchronous read port. The read register only loads when rd_en is high,
// so the read word stays stable between reads.
module wb_ram_responder_byte_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [3:0]            wr_lane,
    input  logic [31:0]           wr_data,
    input  logic                  rd_en,
    output logic [31:0]           rd_data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_byte;

        // Lane write; contents survive reset.
        always_ff @(posedge clk) begin
            if (wr_lane[l]) begin
                mem[idx] <= wr_data[8*l +: 8];
            end
        end

        // Lane read register, cleared by reset, held while rd_en is low.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_byte <= 8'h00;
            end else if (rd_en) begin
                rd_byte <= mem[idx];
            end
        end

        assign rd_data[8*l +: 8] = rd_byte;
    end

endmodule

// File: rtl/wb_ram_responder.sv
// Word-RAM bus responder with byte-lane writes and programmable wait states.
// Decodes its own address window, acks each strobe exactly once and holds
// read data until the next read.
// Optional feature: define WB_RAM_WP_EN to write-protect the first WP_WORDS
// words of the window (writes there are acked but discarded).
module wb_ram_responder
    import wb_ram_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1,
    parameter int          WP_WORDS    = 256
) (
    input  logic                 clk,
    input  logic                 rst_n_i,
    wb_ram_responder_if.slave    bus,
    output state_t               dbg_state
);
    localparam int         TAG_LSB   = ADDR_WIDTH + 2;
    localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_STATES);
    localparam bit         NO_WAIT   = (WAIT_STATES == 0);

    state_t                state;
    logic [3:0]            cnt;
    logic                  ack;
    logic [ADDR_WIDTH-1:0] cap_idx;
    logic                  cap_we;
    logic [3:0]            cap_sel;
    logic [31:0]           cap_dat;

    logic                  hit;
    logic                  in_idle;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  acc_we;
    logic [3:0]            acc_sel;
    logic [31:0]           acc_dat;
    logic                  go_ack;
    logic                  wp_block;
    logic [3:0]            wr_lane;
    logic                  rd_en;
    logic [31:0]           rd_word;

    // Byte offset bits play no part in word addressing.
    logic unused_adr;
    assign unused_adr = ^bus.adr_i[1:0];

    assign hit     = bus.stb_i && (bus.adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign in_idle = (state == ST_IDLE);

    // With zero wait states the RAM access happens on the accept edge, so
    // the live bus values are used; otherwise the captured copy is used.
    assign acc_idx = in_idle ? bus.adr_i[TAG_LSB-1:2] : cap_idx;
    assign acc_we  = in_idle ? bus.we_i  : cap_we;
    assign acc_sel = in_idle ? bus.sel_i : cap_sel;
    assign acc_dat = in_idle ? bus.dat_i : cap_dat;

    // Edge that enters ACK; reset level gates it so a write can never
    // commit while reset is held.
    assign go_ack = rst_n_i && ((in_idle && hit && NO_WAIT) ||
                                ((state == ST_WAIT) && (cnt == 4'd0)));

`ifdef WB_RAM_WP_EN
    assign wp_block = (32'(acc_idx) < 32'(WP_WORDS));
`else
    assign wp_block = 1'b0;
    logic unused_wp;
    assign unused_wp = (WP_WORDS != 0);
`endif

    assign wr_lane = {4{go_ack && acc_we && !wp_block}} & acc_sel;
    assign rd_en   = go_ack && !acc_we;

    wb_ram_responder_byte_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n_i),
        .idx     (acc_idx),
        .wr_lane (wr_lane),
        .wr_data (acc_dat),
        .rd_en   (rd_en),
        .rd_data (rd_word)
    );

    // Transaction FSM: accept, wait out the configured cycles, pulse ack,
    // then wait for the strobe to drop so a trailing strobe is not re-run.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            ack     <= 1'b0;
            cap_idx <= '0;
            cap_we  <= 1'b0;
            cap_sel <= 4'd0;
            cap_dat <= 32'd0;
        end else begin
            ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        cap_idx <= bus.adr_i[TAG_LSB-1:2];
                        cap_we  <= bus.we_i;
                        cap_sel <= bus.sel_i;
                        cap_dat <= bus.dat_i;
                        if (NO_WAIT) begin
                            ack   <= 1'b1;
                            state <= ST_ACK;
                        end else begin
                            cnt   <= WAIT_LOAD;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        ack   <= 1'b1;
                        state <= ST_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!bus.stb_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_o = ack;
    assign bus.dat_o = rd_word;
    assign dbg_state = state;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for the RAM responder. Two instances: unit 0 with one wait
// state at base 0 (WP_WORDS=4), unit 1 with four wait states at 0x1000_0000.
module tb_wb_ram_responder;
    import wb_ram_responder_pkg::*;

    logic clk = 1'b0;
    logic rst_n [2];

    logic        stb [2];
    logic        we  [2];
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [3:0]  sel [2];
    logic        ack_v [2];
    logic [31:0] dout  [2];
    state_t      st    [2];

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model [int];
    logic [31:0] last_rd [2];

    wb_ram_responder_if bus_a ();
    wb_ram_responder_if bus_b ();

    assign bus_a.stb_i = stb[0];
    assign bus_a.we_i  = we[0];
    assign bus_a.adr_i = adr[0];
    assign bus_a.dat_i = dat[0];
    assign bus_a.sel_i = sel[0];
    assign ack_v[0]    = bus_a.ack_o;
    assign dout[0]     = bus_a.dat_o;

    assign bus_b.stb_i = stb[1];
    assign bus_b.we_i  = we[1];
    assign bus_b.adr_i = adr[1];
    assign bus_b.dat_i = dat[1];
    assign bus_b.sel_i = sel[1];
    assign ack_v[1]    = bus_b.ack_o;
    assign dout[1]     = bus_b.dat_o;

    wb_ram_responder #(
        .ADDR_WIDTH (10), .BASE_ADDR (32'h0000_0000), .WAIT_STATES (1), .WP_WORDS (4)
    ) u_dut_a (
        .clk (clk), .rst_n_i (rst_n[0]), .bus (bus_a), .dbg_state (st[0])
    );

    wb_ram_responder #(
        .ADDR_WIDTH (10), .BASE_ADDR (32'h1000_0000), .WAIT_STATES (4), .WP_WORDS (4)
    ) u_dut_b (
        .clk (clk), .rst_n_i (rst_n[1]), .bus (bus_b), .dbg_state (st[1])
    );

    // Clock and global time limit.
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int ws(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] base(input int u);
        return (u == 0) ? 32'h0000_0000 : 32'h1000_0000;
    endfunction

    function automatic int key(input int u, input logic [31:0] a);
        return u * 4096 + int'(a[11:2]);
    endfunction

    task automatic model_wr(input int u, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        logic [31:0] m;
        int k;
        k = key(u, a);
`ifdef WB_RAM_WP_EN
        if (u == 0 && int'(a[11:2]) < 4) return;
`endif
        m = model.exists(k) ? model[k] : 32'hxxxx_xxxx;
        for (int l = 0; l < 4; l++) begin
            if (s[l]) m[8*l +: 8] = d[8*l +: 8];
        end
        model[k] = m;
    endtask

    function automatic logic [31:0] model_rd(input int u, input logic [31:0] a);
        int k;
        k = key(u, a);
        return model.exists(k) ? model[k] : 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One bus transaction: drive, scramble inputs after accept, wait for
    // ack, check latency/data, optionally hold the strobe past ack, then
    // drop it and confirm a single ack and a return to idle.
    task automatic txn(input int u, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input int hold, input bit learn);
        int cyc;
        int acks;
        bit got;
        logic [31:0] e;
        stb[u] = 1'b1; we[u] = w; adr[u] = a; dat[u] = d; sel[u] = s;
        if (w) model_wr(u, a, d, s);
        else if (!learn) exp_q.push_back(model_rd(u, a));
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
            if (ack_v[u] === 1'b1) got = 1'b1;
            else if (cyc == 1) begin
                adr[u] = $urandom; dat[u] = $urandom;
                sel[u] = 4'($urandom_range(0, 15)); we[u] = ~w;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        chk("ack_latency", 32'(cyc), 32'(ws(u) + 1));
        if (w) begin
            chk("wr_keeps_dat_o", dout[u], last_rd[u]);
        end else if (learn) begin
            model[key(u, a)] = dout[u];
            last_rd[u] = dout[u];
        end else begin
            e = exp_q.pop_front();
            chk("rd_data", dout[u], e);
            last_rd[u] = e;
        end
        acks = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (ack_v[u] === 1'b1) acks++;
        end
        stb[u] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack_v[u] === 1'b1) acks++;
        end
        chk("single_ack", 32'(acks), 32'd0);
        chk("dat_o_hold", dout[u], last_rd[u]);
        chk("back_to_idle", 32'(st[u]), 32'(ST_IDLE));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int acks;

        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; stb[u] = 1'b0; we[u] = 1'b0;
            adr[u] = 32'd0; dat[u] = 32'd0; sel[u] = 4'd0; last_rd[u] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #3;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // Reset state of both units.
        for (int u = 0; u < 2; u++) begin
            chk("rst_ack", 32'(ack_v[u]), 32'd0);
            chk("rst_dat", dout[u], 32'd0);
            chk("rst_state", 32'(st[u]), 32'(ST_IDLE));
        end

        // Word write/read, one wait state.
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, SEL_WORD, 0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, SEL_WORD, 0, 1'b0);

        // Byte lane merge.
        txn(0, 1'b1, 32'h20, 32'h1122_3344, SEL_WORD, 0, 1'b0);
        txn(0, 1'b1, 32'h20, 32'h00AA_0000, SEL_BYTE2, 0, 1'b0);
        txn(0, 1'b0, 32'h20, 32'h0, SEL_WORD, 0, 1'b0);

        // Empty lane mask acks without changing memory.
        txn(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 0, 1'b0);
        txn(0, 1'b0, 32'h22, 32'h0, SEL_WORD, 0, 1'b0);

        // Upper halfword on the earlier word.
        txn(0, 1'b1, 32'h10, 32'h1234_0000, SEL_HALF_HI, 1, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, SEL_WORD, 0, 1'b0);

        // Trailing strobe held three cycles past ack.
        txn(0, 1'b1, 32'h30, 32'h0000_0005, SEL_WORD, 3, 1'b0);
        txn(0, 1'b0, 32'h30, 32'h0, SEL_WORD, 2, 1'b0);

        // Protected region at the window start.
`ifdef WB_RAM_WP_EN
        txn(0, 1'b0, 32'h4, 32'h0, SEL_WORD, 0, 1'b1);
        txn(0, 1'b1, 32'h4, 32'hFFFF_FFFF, SEL_WORD, 0, 1'b0);
        txn(0, 1'b0, 32'h4, 32'h0, SEL_WORD, 0, 1'b0);
`else
        txn(0, 1'b1, 32'h4, 32'h0123_4567, SEL_WORD, 0, 1'b0);
        txn(0, 1'b1, 32'h4, 32'hFFFF_FFFF, SEL_WORD, 0, 1'b0);
        txn(0, 1'b0, 32'h4, 32'h0, SEL_WORD, 0, 1'b0);
`endif
        txn(0, 1'b1, 32'h10, 32'hCAFE_F00D, SEL_WORD, 0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, SEL_WORD, 0, 1'b0);

        // Random partial writes on both units.
        for (int i = 0; i < 6; i++) begin
            for (int u = 0; u < 2; u++) begin
                a = base(u) | (32'h200 + 32'(4 * $urandom_range(0, 63)));
                d = $urandom;
                txn(u, 1'b1, a, d, SEL_WORD, 0, 1'b0);
                d = $urandom;
                txn(u, 1'b1, a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 1'b0);
                txn(u, 1'b0, a | 32'($urandom_range(0, 3)), 32'h0, SEL_WORD, 0, 1'b0);
            end
        end

        // Four wait states; byte offset ignored.
        txn(1, 1'b1, 32'h1000_0100, 32'hA5A5_5A5A, SEL_WORD, 0, 1'b0);
        txn(1, 1'b0, 32'h1000_0103, 32'h0, SEL_WORD, 0, 1'b0);

        // Out-of-window strobe never acks.
        stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h0000_0040;
        dat[1] = 32'h7777_7777; sel[1] = SEL_WORD;
        acks = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ack_v[1] === 1'b1) acks++;
        end
        chk("oow_no_ack", 32'(acks), 32'd0);
        chk("oow_dat", dout[1], last_rd[1]);
        chk("oow_state", 32'(st[1]), 32'(ST_IDLE));
        stb[1] = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a waited write.
        txn(1, 1'b1, 32'h1000_0008, 32'h0BAD_F00D, SEL_WORD, 0, 1'b0);
        stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h1000_0008;
        dat[1] = 32'hFFFF_FFFF; sel[1] = SEL_WORD;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_wait", 32'(st[1]), 32'(ST_WAIT));
        rst_n[1] = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ack_v[1]), 32'd0);
        chk("mid_rst_state", 32'(st[1]), 32'(ST_IDLE));
        stb[1] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        last_rd[1] = 32'd0;
        chk("post_rst_state", 32'(st[1]), 32'(ST_IDLE));
        chk("post_rst_dat", dout[1], 32'd0);
        chk("post_rst_ack", 32'(ack_v[1]), 32'd0);
        txn(1, 1'b0, 32'h1000_0008, 32'h0, SEL_WORD, 0, 1'b0);

        // Unit 0 was not disturbed by unit 1 reset.
        txn(0, 1'b0, 32'h30, 32'h0, SEL_WORD, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
